left_shifter_seq: RTL and testbench
===================================

# left_shifter_seq

Sequential 32-bit logical left shifter for the RV32I ALU: implements SLL/SLLI using a start/done handshake. It is the counterpart of the combinational right shifter. A log-shifter is time-multiplexed: one shift-amount bit is applied per cycle, so only one 32-bit shift stage is needed. The ALU control FSM starts it, and the result is written back when done pulses.

## Interface
Parameters:
- none; width fixed at 32 data bits, 5 shift-amount bits.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  request; sampled on rising clk edge
- A  in  32  value to shift; sampled only on the accepting edge
- B  in  5  shift amount (0–31); sampled only on the accepting edge
- busy  out  1  high while a shift is in progress
- done  out  1  one-cycle pulse; Shifted valid
- Shifted  out  32  registered result = A << B; zero-fill from LSB

## Operation
- States: IDLE, SHIFT, DONE. Internal registers:
  - acc[31:0], amt[4:0], stage index k[2:0]
  - result register driving Shifted
- Accept: start=1 at a rising edge while state is IDLE or DONE.
  - On accept: acc<=A, amt<=B, k<=0, state<=SHIFT.
  - start in SHIFT is ignored; no queuing.
- SHIFT, each edge: if amt[k], acc <= acc << (1<<k), discarding bits shifted out of bit 31.
  - Then k<=k+1.
  - After stage k=4 is processed: Shifted<=final acc, state<=DONE.
- DONE lasts exactly one cycle, then IDLE, unless a new start is accepted in that cycle. That gives back-to-back operation: DONE→SHIFT.
- Output decode: busy = (state==SHIFT); done = (state==DONE).
- Shifted changes only on the completion edge. It holds its value through IDLE and through a following SHIFT until the next completion.
- No sign extension or arithmetic mode; left logical only.
- B=0 yields Shifted=A.

## Timing
- Reset values: state=IDLE, busy=0, done=0, Shifted=0x00000000, acc=0, amt=0, k=0.
- Latency without the macro: accepting edge T0 → stages at T1..T5 → done=1 and Shifted valid in the cycle after T5.
  - Latency is a fixed 5 cycles, independent of B.
  - busy=1 from after T0 until after T5.
- Throughput: one result per 6 cycles. Start in the DONE cycle gives a new done 6 cycles after the previous done.
- Reset asserted mid-operation: immediately (asynchronously) returns to IDLE, busy=0, done=0, Shifted=0. The in-flight operation is lost; no done is produced for it.
- Reset released: first acceptable start is at the first rising edge with rst_n=1.
- A and B may change freely after the accepting edge without effect.

## Configuration
- SHIFTER_EARLY_DONE_EN defined:
  - After processing stage k, if amt bits above k are all zero, complete on that same edge: Shifted<=acc, state<=DONE.
  - Latency = 1 + index of the highest set bit of B; latency is 1 when B=0.
  - Examples: B=0 or 1 → 1 cycle; B=2,3 → 2; B=16–31 → 5.
- Not defined: fixed 5-cycle latency as above. The remaining-bits check is not synthesized.
- Results are identical in both configurations; only done timing differs.

## Test plan
- Single-bit walk: A=0x00000001, B=31 → Shifted=0x80000000, done high exactly 5 cycles after the accepting edge (macro off); busy high for those 5 cycles.
- Exhaustive B sweep, one check per shift amount:
  - A=0xFFFFFFFF, B=0..31 → Shifted=A<<B each time, e.g. B=4 → 0xFFFFFFF0.
  - Repeat with A=0x80000001: B=1 → 0x00000002, B=0 → 0x80000001.
- Start while busy: start A=0x1,B=3; pulse start again at T2 with A=0xF,B=1.
  - Required: a single done, Shifted=0x00000008.
  - busy never deasserts early.
- Back-to-back start asserted in the DONE cycle:
  - A=0x3,B=2 → first done with 0x0000000C.
  - Next op A=0x1,B=8 → second done 6 cycles later with 0x00000100; Shifted holds 0x0000000C until then.
- Reset mid-operation: start A=0x12345678,B=5, assert rst_n=0 at T3 between edges.
  - Required: busy, done and Shifted go to 0 immediately.
  - No done after release; next op A=0x1,B=1 → 0x00000002.
- With SHIFTER_EARLY_DONE_EN:
  - B=0 → done 1 cycle after accept, Shifted=A.
  - B=5 → 3 cycles; B=16 → 5 cycles.
  - Values equal A<<B.

Source files
------------

// File: rtl/left_shifter_seq.sv
// Sequential 32-bit logical left shifter (SLL/SLLI): one log-shifter stage per cycle, start/done handshake.
// Latency: 5 cycles from accepting edge to done; with SHIFTER_EARLY_DONE_EN, 1 + index of highest set bit of B.
// Backpressure: none; start is accepted only in IDLE or DONE, and start while busy is ignored (no queuing).
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start, A, B       request; A (value) and B (shift amount) are sampled only on the accepting edge
//   busy              high while a shift is in progress
//   done              one-cycle pulse; Shifted is valid
//   Shifted           registered result A << B, zero-filled from the LSB
//
// Optional macro: SHIFTER_EARLY_DONE_EN -- complete as soon as no higher shift-amount bits remain.
module left_shifter_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [4:0]  B,
    output logic        busy,
    output logic        done,
    output logic [31:0] Shifted
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] acc_q;
    logic [31:0] acc_d;
    logic [4:0]  amt_q;
    logic [2:0]  k_q;
    logic [31:0] shifted_q;
    logic        busy_q;
    logic        done_q;
    logic        last_stage;

    // One stage of the log-shifter: stage k shifts by 2^k when amount bit k is set.
    always_comb begin
        acc_d = acc_q;
        case (k_q)
            3'd0:    if (amt_q[0]) acc_d = {acc_q[30:0], 1'b0};
            3'd1:    if (amt_q[1]) acc_d = {acc_q[29:0], 2'b0};
            3'd2:    if (amt_q[2]) acc_d = {acc_q[27:0], 4'b0};
            3'd3:    if (amt_q[3]) acc_d = {acc_q[23:0], 8'b0};
            3'd4:    if (amt_q[4]) acc_d = {acc_q[15:0], 16'b0};
            default: acc_d = acc_q;
        endcase
    end

`ifdef SHIFTER_EARLY_DONE_EN
    // Amount bits above the current stage; once they are all zero the
    // remaining stages would not change acc, so finish on this edge.
    logic [4:0] rem_bits;
    always_comb begin
        rem_bits   = amt_q >> (k_q + 3'd1);
        last_stage = (k_q == 3'd4) || (rem_bits == 5'd0);
    end
`else
    always_comb begin
        last_stage = (k_q == 3'd4);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            amt_q     <= '0;
            k_q       <= '0;
            shifted_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    // DONE accepts a new start so operations can run back-to-back.
                    if (start) begin
                        acc_q   <= A;
                        amt_q   <= B;
                        k_q     <= 3'd0;
                        state_q <= SHIFT;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                SHIFT: begin
                    acc_q <= acc_d;
                    k_q   <= k_q + 3'd1;
                    if (last_stage) begin
                        shifted_q <= acc_d;
                        state_q   <= DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // busy_q/done_q are updated in lockstep with state_q, so they equal
    // (state==SHIFT) and (state==DONE) but come straight from flops.
    assign busy    = busy_q;
    assign done    = done_q;
    assign Shifted = shifted_q;

endmodule

// File: tb/tb_left_shifter_seq.sv
module tb_left_shifter_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] A;
    logic [4:0]  B;
    logic        busy;
    logic        done;
    logic [31:0] Shifted;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cyc = 0;
    logic [31:0] last_res = 32'h0;

    left_shifter_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .done    (done),
        .Shifted (Shifted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: latency in edges from the accepting edge to done.
    function automatic int exp_lat(input logic [4:0] b);
`ifdef SHIFTER_EARLY_DONE_EN
        int h = 0;
        for (int i = 0; i < 5; i++) if (b[i]) h = i;
        return h + 1;
`else
        return 5;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Called at #1 after an edge; presents a request and steps past the accepting edge.
    task automatic issue(input logic [31:0] a, input logic [4:0] b);
        start = 1'b1;
        A     = a;
        B     = b;
        @(posedge clk); #1;
        start = 1'b0;
        A     = $urandom;
        B     = 5'($urandom);
    endtask

    // n0 = edges already elapsed since the accepting edge.
    task automatic wait_done(input string tag, input int n0, input logic [31:0] a, input logic [4:0] b);
        int n = n0;
        logic [31:0] res;
        res = a << b;
        while (done !== 1'b1 && n < 12) begin
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_hold"}, Shifted, last_res);
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'(exp_lat(b)));
        chk({tag, "_res"}, Shifted, res);
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd1);
        last_res = res;
        done_cyc = cyc;
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [4:0] b);
        issue(a, b);
        wait_done(tag, 0, a, b);
    endtask

    // One idle edge after done: pulse must end and the result must hold.
    task automatic idle_check(input string tag);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_idle_hold"}, Shifted, last_res);
    endtask

    initial begin
        int c1;
        logic [31:0] ra;
        logic [4:0]  rb;

        rst_n = 1'b0;
        start = 1'b0;
        A     = '0;
        B     = '0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_shifted", Shifted, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single-bit walk, started on the first edge after reset release.
        run_op("walk", 32'h0000_0001, 5'd31);
        chk("walk_const", Shifted, 32'h8000_0000);
        idle_check("walk");

        // Exhaustive shift-amount sweeps.
        for (int b = 0; b < 32; b++) begin
            run_op("sweepF", 32'hFFFF_FFFF, 5'(b));
            idle_check("sweepF");
        end
        for (int b = 0; b < 32; b++) begin
            run_op("sweep81", 32'h8000_0001, 5'(b));
            idle_check("sweep81");
        end

        // Start while busy: the second request at T2 must be ignored.
        issue(32'h1, 5'd3);
        chk("sib_busy1", 32'(busy), 32'd1);
        @(posedge clk); #1;
        start = 1'b1;
        A     = 32'hF;
        B     = 5'd1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("sib", 2, 32'h1, 5'd3);
        chk("sib_const", Shifted, 32'h0000_0008);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("sib_single_done", 32'(done), 32'd0);
        end
        chk("sib_final", Shifted, 32'h0000_0008);

        // Back-to-back: next start issued in the DONE cycle.
        run_op("b2b1", 32'h3, 5'd2);
        chk("b2b1_const", Shifted, 32'h0000_000C);
        c1 = done_cyc;
        run_op("b2b2", 32'h1, 5'd8);
        chk("b2b2_const", Shifted, 32'h0000_0100);
        chk("b2b_gap", 32'(done_cyc - c1), 32'(exp_lat(5'd8) + 1));
        idle_check("b2b");

        // Reset mid-operation, asserted between edges.
        issue(32'h1234_5678, 5'd5);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mrst_busy_pre", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_shifted", Shifted, 32'h0);
        last_res = 32'h0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("mrst_no_done", 32'(done), 32'd0);
            chk("mrst_idle_busy", 32'(busy), 32'd0);
        end
        run_op("post_rst", 32'h1, 5'd1);
        chk("post_rst_const", Shifted, 32'h0000_0002);
        idle_check("post_rst");

`ifdef SHIFTER_EARLY_DONE_EN
        run_op("early_b0", 32'hA5A5_0F0F, 5'd0);
        chk("early_b0_eq_a", Shifted, 32'hA5A5_0F0F);
        idle_check("early_b0");
        run_op("early_b5", 32'h0000_0003, 5'd5);
        idle_check("early_b5");
        run_op("early_b16", 32'h0000_ABCD, 5'd16);
        idle_check("early_b16");
`endif

        // Randomized operations, some back-to-back and some with idle gaps.
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = 5'($urandom_range(0, 31));
            run_op("rand", ra, rb);
            if ($urandom_range(0, 1) == 0) idle_check("rand");
        end
        idle_check("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
